// File: rtl/formant_backtrack.sv
// -----------------------------------------------------------------------------
// formant_backtrack
//
// Walks the backpointer table B(k,i) produced by the F/B dynamic-programming
// stage, starting at (k_total, i_last) and moving backwards. It produces one
// frame segment per formant, in order k_total down to 1. The table lives
// outside this block. Each read is a one-cycle req_valid strobe, and the data
// returns on b_in exactly RD_LAT cycles later. Segments leave through a
// valid/ready handshake.
//
// Optional feature: define BACKTRACK_CHECK_EN to range-check every returned
// backpointer. A bad entry stops the walk with error set. It does this instead
// of emitting a segment built from garbage.
//
// Ports:
//   clk_in     clock
//   rst_n_in   synchronous active-low reset
//   start      pulse: latch i_last / k_total and begin a backtrace (IDLE only)
//   i_last     last frame index of the utterance
//   k_total    number of segments, 1..FORMANTS
//   k_req      formant index of the current table read
//   i_req      frame index of the current table read
//   req_valid  one-cycle read strobe
//   b_in       B(k_req,i_req), signed, valid RD_LAT cycles after req_valid
//   seg_k      formant index of the presented segment
//   seg_start  first frame of the segment (b+1)
//   seg_end    last frame of the segment (i)
//   seg_valid  segment is presented
//   seg_ready  downstream accepts the segment
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse at the end of the backtrace
//   error      sticky malformed-table/argument flag, cleared by the next start
// -----------------------------------------------------------------------------
module formant_backtrack #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int FORMANTS  = 5,
  parameter int RD_LAT    = 2,
  localparam int IW       = $clog2(I),
  localparam int KW       = $clog2(FORMANTS)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start,
  input  logic [IW-1:0]        i_last,
  input  logic [KW:0]          k_total,
  output logic [KW-1:0]        k_req,
  output logic [IW-1:0]        i_req,
  output logic                 req_valid,
  input  logic [BIT_WIDTH-1:0] b_in,
  output logic [KW-1:0]        seg_k,
  output logic [IW-1:0]        seg_start,
  output logic [IW-1:0]        seg_end,
  output logic                 seg_valid,
  input  logic                 seg_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);
  localparam logic [KW:0]   K_ONE    = 1;
  localparam logic [KW:0]   K_MAX    = FORMANTS[KW:0];
  localparam logic [IW:0]   I_ONE    = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_t;

  state_t          state;
  logic [KW:0]     k_cur;     // one bit wider than k_req so k==FORMANTS always fits
  logic [IW-1:0]   i_cur;
  logic [IW-1:0]   b_lo;      // captured backpointer, becomes the next i_cur
  logic [CW-1:0]   cnt;

  // The returned word is signed. Only IW+1 bits matter: the range -1..I-1.
  logic [IW:0]     b_new;
  assign b_new = b_in[IW:0];

  // The upper bits of the table word carry no information for the walk.
  logic unused_bits;
  assign unused_bits = ^b_in[BIT_WIDTH-1:IW];

  // Start arguments are malformed when no segment count is given, or when the
  // count is too large, or when there are fewer frames than segments (every
  // segment needs at least one frame).
  // i_last < k_total-1 is rewritten as i_last+1 < k_total to avoid underflow.
  logic        start_bad;
  logic [IW:0] i_last_p1;
  logic [IW:0] k_total_ext;

  always_comb begin
    i_last_p1   = {1'b0, i_last} + I_ONE;
    k_total_ext = {{(IW - KW){1'b0}}, k_total};
    start_bad   = (k_total == '0) || (k_total > K_MAX) || (i_last_p1 < k_total_ext);
  end

  logic b_ok;

`ifdef BACKTRACK_CHECK_EN
  localparam logic signed [IW+1:0] S_ONE   = 1;
  localparam logic signed [IW+1:0] S_TWO   = 2;
  localparam logic signed [IW+1:0] S_M_ONE = -1;

  logic signed [IW+1:0] b_ext;
  logic signed [IW+1:0] b_min;
  logic signed [IW+1:0] b_max;

  // A backpointer for formant k at frame i must leave k-1 frames for the
  // remaining k-1 formants (b >= k-2) and must stay before i (b <= i-1).
  // The last formant must reach back to the start of the utterance (b == -1).
  always_comb begin
    b_ext = signed'({b_new[IW], b_new});
    b_min = signed'({{(IW + 1 - KW){1'b0}}, k_cur}) - S_TWO;
    b_max = signed'({2'b00, i_cur}) - S_ONE;
    b_ok  = (b_ext >= b_min) && (b_ext <= b_max);
    if ((k_cur == K_ONE) && (b_ext != S_M_ONE)) begin
      b_ok = 1'b0;
    end
  end
`else
  // Entries are trusted; only the start arguments are validated.
  assign b_ok = 1'b1;
`endif

  // NOTE: every register here is written with non-blocking assignments.
  // Each next-state expression then reads the values from before the edge,
  // whatever order the statements appear in.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state     <= S_IDLE;
      k_cur     <= '0;
      i_cur     <= '0;
      b_lo      <= '0;
      cnt       <= '0;
      k_req     <= '0;
      i_req     <= '0;
      req_valid <= 1'b0;
      seg_k     <= '0;
      seg_start <= '0;
      seg_end   <= '0;
      seg_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // Strobes default low, so each one lasts only the single cycle it is set.
      req_valid <= 1'b0;
      done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            k_cur <= k_total;
            i_cur <= i_last;
            busy  <= 1'b1;
            if (start_bad) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              error     <= 1'b0;
              // The request is registered on entry to REQ. That way
              // req_valid is high during exactly the REQ cycle.
              req_valid <= 1'b1;
              k_req     <= k_total[KW-1:0];
              i_req     <= i_last;
              state     <= S_REQ;
            end
          end
        end

        S_REQ: begin
          cnt   <= CNT_LOAD;
          state <= S_WAIT;
        end

        S_WAIT: begin
          // cnt reaches zero in the cycle RD_LAT after req_valid, which is
          // the only cycle in which b_in belongs to this request.
          if (cnt == '0) begin
            b_lo <= b_new[IW-1:0];
            if (b_ok) begin
              seg_k     <= k_cur[KW-1:0];
              seg_start <= b_new[IW-1:0] + IW'(1);  // b == -1 wraps to frame 0
              seg_end   <= i_cur;
              seg_valid <= 1'b1;
              state     <= S_EMIT;
            end else begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_FIN;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_EMIT: begin
          // seg_valid is always high in EMIT, so seg_ready alone completes
          // the handshake. The seg_* registers are left alone until then.
          if (seg_ready) begin
            seg_valid <= 1'b0;
            if (k_cur == K_ONE) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              k_cur     <= k_cur - K_ONE;
              i_cur     <= b_lo;
              req_valid <= 1'b1;
              k_req     <= k_cur[KW-1:0] - 1'b1;
              i_req     <= b_lo;
              state     <= S_REQ;
            end
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_formant_backtrack.sv
// -----------------------------------------------------------------------------
// tb_formant_backtrack
//
// Directed bench for formant_backtrack. It has a small behavioural model of
// the external B table. The model answers each req_valid exactly RD_LAT
// cycles later and drives a junk word at all other times. Outputs are sampled
// 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_formant_backtrack;

  localparam int BW     = 32;
  localparam int IW     = 8;
  localparam int KW     = 3;
  localparam int RD_LAT = 2;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic          clk_in   = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start    = 1'b0;
  logic [IW-1:0] i_last   = '0;
  logic [KW:0]   k_total  = '0;
  logic [KW-1:0] k_req;
  logic [IW-1:0] i_req;
  logic          req_valid;
  logic [BW-1:0] b_in;
  logic [KW-1:0] seg_k;
  logic [IW-1:0] seg_start;
  logic [IW-1:0] seg_end;
  logic          seg_valid;
  logic          seg_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          error;

  int errors    = 0;
  int checks    = 0;
  int table_sel = 0;
  int req_cnt   = 0;

  formant_backtrack #(
    .BIT_WIDTH(BW),
    .I(160),
    .FORMANTS(5),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start    (start),
    .i_last   (i_last),
    .k_total  (k_total),
    .k_req    (k_req),
    .i_req    (i_req),
    .req_valid(req_valid),
    .b_in     (b_in),
    .seg_k    (seg_k),
    .seg_start(seg_start),
    .seg_end  (seg_end),
    .seg_valid(seg_valid),
    .seg_ready(seg_ready),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk_in = ~clk_in;

  // Table 0: the well-formed utterance. Table 1: B(2,5) points past its frame.
  function automatic logic [31:0] lookup(int sel, logic [KW-1:0] k, logic [IW-1:0] i);
    if (sel == 0) begin
      if (k == 3'd3 && i == 8'd9)   return 32'd5;
      if (k == 3'd2 && i == 8'd5)   return 32'd2;
      if (k == 3'd1 && i == 8'd2)   return 32'hFFFF_FFFF;
      if (k == 3'd1 && i == 8'd159) return 32'hFFFF_FFFF;
    end else begin
      if (k == 3'd3 && i == 8'd9)   return 32'd5;
      if (k == 3'd2 && i == 8'd5)   return 32'd7;
      if (k == 3'd1 && i == 8'd7)   return 32'hFFFF_FFFF;
    end
    return JUNK;
  endfunction

  // External memory model: read data appears RD_LAT cycles after the strobe.
  logic [31:0] pipe [RD_LAT];
  always @(posedge clk_in) begin
    pipe[0] <= req_valid ? lookup(table_sel, k_req, i_req) : JUNK;
    for (int j = 1; j < RD_LAT; j++) pipe[j] <= pipe[j-1];
  end
  assign b_in = pipe[RD_LAT-1];

  always @(negedge clk_in) if (req_valid) req_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, observed, observed, expected, expected);
    end
  endtask

  task automatic check_cleared(string tag);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_seg_valid"}, seg_valid, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_error"},     error, 0);
    check({tag, "_k_req"},     k_req, 0);
    check({tag, "_i_req"},     i_req, 0);
    check({tag, "_seg_k"},     seg_k, 0);
    check({tag, "_seg_start"}, seg_start, 0);
    check({tag, "_seg_end"},   seg_end, 0);
  endtask

  task automatic do_start(int k, int i);
    k_total = (KW+1)'(k);
    i_last  = IW'(i);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Waits (bounded) for a presented segment and checks its fields and latency.
  // It returns with the segment still presented. The caller decides when to
  // complete the handshake.
  task automatic expect_seg(string tag, int k, int s, int e);
    int n = 0;
    while (!seg_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_present"}, seg_valid, 1);
    check({tag, "_latency"}, n, RD_LAT + 1);
    check({tag, "_k"},       seg_k, k);
    check({tag, "_start"},   seg_start, s);
    check({tag, "_end"},     seg_end, e);
  endtask

  int base;
  int n;
  bit saw_seg;

  initial begin
    for (int j = 0; j < RD_LAT; j++) pipe[j] = JUNK;

    // Reset state.
    rst_n_in = 1'b0;
    tick();
    tick();
    check_cleared("reset");
    rst_n_in  = 1'b1;
    seg_ready = 1'b1;
    tick();

    // Walk 1: three segments with seg_ready held high.
    table_sel = 0;
    base = req_cnt;
    do_start(3, 9);
    check("w1_req_valid", req_valid, 1);
    check("w1_k_req", k_req, 3);
    check("w1_i_req", i_req, 9);
    check("w1_busy", busy, 1);
    expect_seg("w1_s3", 3, 6, 9);
    tick();
    expect_seg("w1_s2", 2, 3, 5);
    tick();
    expect_seg("w1_s1", 1, 0, 2);
    tick();
    check("w1_done", done, 1);
    check("w1_busy_fin", busy, 1);
    check("w1_error", error, 0);
    check("w1_reqs", req_cnt - base, 3);
    tick();
    check("w1_done_drop", done, 0);
    check("w1_busy_drop", busy, 0);

    // Walk 2: downstream stalls the second segment for 4 cycles.
    base = req_cnt;
    do_start(3, 9);
    expect_seg("w2_s3", 3, 6, 9);
    tick();
    seg_ready = 1'b0;
    expect_seg("w2_s2", 2, 3, 5);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("w2_hold_valid", seg_valid, 1);
      check("w2_hold_k", seg_k, 2);
      check("w2_hold_start", seg_start, 3);
      check("w2_hold_end", seg_end, 5);
      check("w2_hold_noreq", req_cnt - base, 2);
    end
    seg_ready = 1'b1;
    tick();
    check("w2_drop_valid", seg_valid, 0);
    expect_seg("w2_s1", 1, 0, 2);
    tick();
    check("w2_done", done, 1);
    check("w2_reqs", req_cnt - base, 3);
    tick();

    // Walk 3: a single segment covering the whole utterance.
    base = req_cnt;
    do_start(1, 159);
    expect_seg("w3_s1", 1, 0, 159);
    tick();
    check("w3_done", done, 1);
    check("w3_reqs", req_cnt - base, 1);
    tick();

    // Walk 4: fewer frames than segments, then a valid start clears error.
    base = req_cnt;
    do_start(4, 2);
    check("w4_req_valid", req_valid, 0);
    check("w4_error", error, 1);
    check("w4_done", done, 1);
    tick();
    check("w4_done_drop", done, 0);
    check("w4_error_sticky", error, 1);
    check("w4_busy_drop", busy, 0);
    check("w4_reqs", req_cnt - base, 0);
    do_start(1, 159);
    check("w4_error_clear", error, 0);
    expect_seg("w4_s1", 1, 0, 159);
    tick();
    check("w4_done2", done, 1);
    tick();

    // Walk 5: malformed backpointer B(2,5)=7.
    table_sel = 1;
    do_start(3, 9);
    expect_seg("w5_s3", 3, 6, 9);
    tick();
`ifdef BACKTRACK_CHECK_EN
    n = 0;
    saw_seg = 1'b0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (seg_valid) saw_seg = 1'b1;
    end
    check("w5_done", done, 1);
    check("w5_no_seg", saw_seg, 0);
    check("w5_error", error, 1);
`else
    expect_seg("w5_s2", 2, 8, 5);
    tick();
    expect_seg("w5_s1", 1, 0, 7);
    tick();
    check("w5_done", done, 1);
    check("w5_error", error, 0);
`endif
    tick();

    // Walk 6: reset during WAIT. The stale read return must be ignored.
    table_sel = 0;
    do_start(3, 9);
    tick();
    rst_n_in = 1'b0;
    tick();
    check_cleared("rst_wait_a");
    tick();
    check_cleared("rst_wait_b");
    rst_n_in = 1'b1;
    base = req_cnt;
    do_start(1, 159);
    check("w6_req_valid", req_valid, 1);
    check("w6_k_req", k_req, 1);
    check("w6_i_req", i_req, 159);
    expect_seg("w6_s1", 1, 0, 159);
    tick();
    check("w6_done", done, 1);
    check("w6_reqs", req_cnt - base, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/formant_backtrack.md
Name: formant_backtrack

Overview:
- Downstream consumer of the F/B dynamic-programming stage.
- Once every frame i has been processed, this block walks the stored backpointer table B(k,i) backwards from (k_total, i_last). It emits one frame segment per formant, in order k_total down to 1.
- Table storage is external. The block issues read requests and receives data a fixed RD_LAT cycles later.
- Segments are handed to the downstream consumer through a valid/ready handshake.

Parameters:
- BIT_WIDTH, 32, width of the stored B entries (b_data word).
- I, 160, frames per utterance; index width IW = $clog2(I).
- FORMANTS, 5, maximum segment count; k width KW = $clog2(FORMANTS).
- RD_LAT, 2, cycles from req_valid to b_in being valid.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  synchronous active-low reset
- start  input  1  pulse; latch i_last and k_total, begin backtrace
- i_last  input  IW  last frame index (normally I-1)
- k_total  input  KW+1  number of segments, 1..FORMANTS
- k_req  output  KW  B-table formant index being requested
- i_req  output  IW  B-table frame index being requested
- req_valid  output  1  one-cycle read strobe
- b_in  input  BIT_WIDTH  B(k_req,i_req), signed, valid RD_LAT cycles after req_valid
- seg_k  output  KW  formant index of the current segment
- seg_start  output  IW  first frame of the segment (b+1)
- seg_end  output  IW  last frame of the segment (i)
- seg_valid  output  1  segment is presented
- seg_ready  input  1  downstream accepts the segment
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at the end of the backtrace
- error  output  1  sticky malformed-table flag; cleared by the next accepted start

Behaviour:
- Reset (rst_n_in low at a clock edge): state=IDLE. req_valid, seg_valid, busy, done and error all clear to 0. k_req, i_req, seg_k, seg_start and seg_end clear to 0. Reset mid-operation abandons the walk immediately; any in-flight read return is ignored.
- States: IDLE, REQ, WAIT, EMIT, FIN.
- IDLE: on start, latch k_cur=k_total and i_cur=i_last, clear error, go to REQ.
  - If k_total==0, k_total>FORMANTS, or i_last < k_total-1, set error and go to FIN.
- Start in any state other than IDLE is ignored.
- REQ: drive k_req=k_cur, i_req=i_cur and req_valid=1 for exactly one cycle. Load the wait counter with RD_LAT-1, go to WAIT.
- WAIT: decrement the counter. In the cycle b_in is valid (RD_LAT cycles after req_valid), capture b = signed b_in, truncated to IW+1 bits, and go to EMIT.
- EMIT, on entry:
  - Register seg_k=k_cur, seg_start=b+1 and seg_end=i_cur.
  - Assert seg_valid.
  - Hold all seg_* stable while seg_ready is low.
- On the cycle seg_valid && seg_ready:
  - Drop seg_valid.
  - If k_cur==1, go to FIN.
  - Otherwise set k_cur=k_cur-1, i_cur=b, and go to REQ.
- Minimum time per segment is RD_LAT+2 cycles when seg_ready is held high.
- FIN: pulse done for one cycle, drop busy, return to IDLE.
- Segment chain property: seg_start of segment k equals seg_end+1 of segment k-1. The k=1 segment always has seg_start=0.
- busy is high in the REQ, WAIT and EMIT states and in the FIN cycle.

Optional Feature:
- Macro BACKTRACK_CHECK_EN.
- When defined, each captured b is checked against the following rules:
  - A valid b satisfies k_cur-2 <= b <= i_cur-1.
  - When k_cur==1, b must equal -1.
  - On violation: no segment is emitted, error is set, go to FIN.
- When not defined:
  - No per-entry checks are made and b is trusted.
  - The start-time argument checks remain.
  - error is set only by those start-time checks.

Test Plan:
- Table k_total=3, i_last=9 with B(3,9)=5, B(2,5)=2, B(1,2)=-1, seg_ready=1 → three segments (k,start,end) = (3,6,9), (2,3,5), (1,0,2). done pulses one cycle after the last handshake; error=0.
- Same table, seg_ready low for 4 cycles on the second segment → seg_* held stable with seg_valid=1 throughout, no new req_valid, and the sequence is unchanged.
- k_total=1, i_last=159, B(1,159)=-1 → single segment (1,0,159), exactly one req_valid, done pulses.
- start with k_total=4, i_last=2 → no req_valid, error=1, done pulse within 2 cycles. A later valid start clears error.
- With BACKTRACK_CHECK_EN: B(2,5)=7 (b > i-1) → no segment for k=2, error=1, done pulses. Without the macro, segment (2,8,5) is emitted instead.
- Reset asserted during WAIT, then start while seg_ready=1 → all outputs 0 during reset and the stale b_in return is ignored; after reset the new walk runs from its first request.
